ex_stage_alu_driver: RTL and testbench
======================================

Name: ex_stage_alu_driver

Overview:
- Execute-stage front end of the 5-stage pipelined MIPS core.
- Holds the ID/EX pipeline register and decodes ALUOp/funct into the 4-bit ALU control code.
- Resolves operand forwarding and drives the ALU's IN1/IN2/CONTROL inputs, then latches the ALU's OUT/ZERO into the EX/MEM register.
- The ALU itself stays external and purely combinational; this block is its producer and its consumer.

Parameters:
- WIDTH, 32, datapath width of operands and results.
- REGBITS, 5, register-number width.

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-high reset.
- STALL  in  1  freeze both pipeline registers this cycle.
- FLUSH  in  1  replace the incoming ID/EX entry with a bubble.
- ID_VALID  in  1  decode stage presents a real instruction.
- ID_RS, ID_RT, ID_RD  in  REGBITS  source and destination register numbers.
- ID_RS_DATA, ID_RT_DATA  in  WIDTH  register-file read data.
- ID_IMM  in  WIDTH  sign-extended immediate.
- ID_PC4  in  WIDTH  PC+4 of the instruction.
- ID_ALUSRC  in  1  1 selects ID_IMM as the second operand.
- ID_ALUOP  in  2  00 add, 01 sub, 10 R-type, 11 or-immediate.
- ID_FUNCT  in  6  R-type funct field.
- ID_REGWRITE, ID_BRANCH  in  1  control bits.
- WB_REGWRITE  in  1  write-back stage write enable.
- WB_RD  in  REGBITS  write-back destination.
- WB_DATA  in  WIDTH  write-back data.
- ALU_IN1, ALU_IN2  out  WIDTH  ALU operands.
- ALU_CONTROL  out  4  ALU operation code.
- ALU_OUT  in  WIDTH  ALU result.
- ALU_ZERO  in  1  ALU zero flag.
- MEM_VALID, MEM_REGWRITE  out  1  EX/MEM control.
- MEM_RESULT  out  WIDTH  latched ALU_OUT.
- MEM_STORE_DATA  out  WIDTH  forwarded rt value.
- MEM_RD  out  REGBITS  destination register.
- BR_TAKEN  out  1  registered branch decision.
- BR_TARGET  out  WIDTH  registered branch target.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high; all register updates occur on the rising edge of CLK.
- Reset values:
  - Every ID/EX and EX/MEM field is cleared to 0, so all registered outputs read 0.
  - With the EX entry invalid, ALU_CONTROL = 4'b1111.
- Update priority per edge: RESET > STALL > FLUSH > normal.
- STALL:
  - Both registers hold their contents.
  - ALU inputs recompute from the held entry, so forwarding tracks WB changes.
- FLUSH without STALL:
  - ID/EX captures a bubble: valid=0, regwrite=0, branch=0, all other fields 0.
  - EX/MEM captures normally.
- ID_VALID=0 is captured as a bubble.
- Latency:
  - An instruction accepted at edge n drives the ALU combinationally during cycle n.
  - Its result appears on the MEM_* outputs after edge n+1.
  - Throughput is one instruction per cycle.
- ALU_CONTROL decode, applied when the EX entry is valid:
  - ALUOp 00 -> 0010 (add).
  - ALUOp 01 -> 0110 (sub).
  - ALUOp 11 -> 0011 (or).
  - ALUOp 10 decodes the funct field: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0011, 101010 -> 0100. Any other funct -> 1111.
  - An invalid EX entry -> 1111.
- Forwarding, evaluated independently for rs (A) and rt (B):
  - Priority 1: if MEM_REGWRITE & MEM_VALID & MEM_RD!=0 & MEM_RD==ex_reg, select MEM_RESULT.
  - Priority 2: else if WB_REGWRITE & WB_RD!=0 & WB_RD==ex_reg, select WB_DATA.
  - Otherwise select the latched register data.
  - Register 0 is never forwarded.
- Operand muxing:
  - ALU_IN1 = forwarded A.
  - ALU_IN2 = ID_ALUSRC(latched) ? latched imm : forwarded B.
  - MEM_STORE_DATA captures forwarded B.
- EX/MEM capture:
  - MEM_RESULT = ALU_OUT.
  - MEM_VALID and MEM_REGWRITE copy the EX entry's bits. A bubble yields 0 for both.
  - BR_TAKEN = valid & branch & ALU_ZERO.
  - BR_TARGET = pc4 + (imm << 2), wrapping modulo 2^WIDTH.
- Simultaneous events:
  - FLUSH during STALL is ignored; the held entry survives.
  - RESET mid-stall clears everything.
- The block never inspects ALU_OUT for overflow. Add and subtract wrap.

Test Plan:
- Reset: assert RESET for 2 cycles with arbitrary inputs -> every MEM_* output and BR_* output is 0; ALU_CONTROL=1111; ALU_IN1=ALU_IN2=0.
- R-type add: rs=$1 holding 5, rt=$2 holding 7, ALUOP=10, FUNCT=100000, model ALU returns the sum -> cycle after capture: ALU_CONTROL=0010, IN1=5, IN2=7; next edge: MEM_RESULT=12, MEM_RD=3, MEM_REGWRITE=1.
- Back-to-back forwarding:
  - First: add $3=12 at edge n.
  - Second: sub $4=$3-$1 with rs=$3 and stale ID_RS_DATA=0, captured at edge n+1.
  - Expected: ALU_IN1=12 (forwarded from MEM) and ALU_CONTROL=0110.
  - Repeat with WB_RD=3, WB_DATA=9 also asserted: the MEM path still wins.
- Branch: beq with both operands 4, imm=3, pc4=0x100 -> ALU_CONTROL=0110; after the next edge BR_TAKEN=1, BR_TARGET=0x10C. Repeat with operands 4/5 -> BR_TAKEN=0.
- Stall/flush:
  - Hold STALL for 3 cycles mid-stream -> MEM_* outputs unchanged, ALU inputs stable.
  - FLUSH+STALL together -> entry kept.
  - FLUSH alone -> next MEM_VALID=0, MEM_REGWRITE=0, ALU_CONTROL=1111.
- Decode edges:
  - funct 101010 -> 0100.
  - funct 100101 -> 0011.
  - Undefined funct 000111 -> 1111.
  - ALUOP=11 with ALUSRC=1, imm=0xF0 -> IN2=0xF0, CONTROL=0011.

Source files
------------

// File: rtl/ex_stage_alu_driver.sv
// Execute-stage front end: ID/EX register, ALU control decode, operand
// forwarding toward the external combinational ALU, and the EX/MEM register
// that captures the ALU result and the branch decision.

// One operand's forwarding mux. MEM beats WB, and register 0 never forwards.
module ex_fwd_mux #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic [REGBITS-1:0] ex_reg,
  input  logic [WIDTH-1:0]   reg_data,
  input  logic               mem_fwd_en,
  input  logic [REGBITS-1:0] mem_rd,
  input  logic [WIDTH-1:0]   mem_data,
  input  logic               wb_fwd_en,
  input  logic [REGBITS-1:0] wb_rd,
  input  logic [WIDTH-1:0]   wb_data,
  output logic [WIDTH-1:0]   fwd_data
);
  logic hit_mem, hit_wb;

  // Priority select: newest producer (MEM) first, then WB, else register file.
  always_comb begin
    hit_mem  = mem_fwd_en && (mem_rd != '0) && (mem_rd == ex_reg);
    hit_wb   = wb_fwd_en  && (wb_rd  != '0) && (wb_rd  == ex_reg);
    fwd_data = reg_data;
    if (hit_mem)     fwd_data = mem_data;
    else if (hit_wb) fwd_data = wb_data;
  end
endmodule

module ex_stage_alu_driver #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               STALL,
  input  logic               FLUSH,
  input  logic               ID_VALID,
  input  logic [REGBITS-1:0] ID_RS,
  input  logic [REGBITS-1:0] ID_RT,
  input  logic [REGBITS-1:0] ID_RD,
  input  logic [WIDTH-1:0]   ID_RS_DATA,
  input  logic [WIDTH-1:0]   ID_RT_DATA,
  input  logic [WIDTH-1:0]   ID_IMM,
  input  logic [WIDTH-1:0]   ID_PC4,
  input  logic               ID_ALUSRC,
  input  logic [1:0]         ID_ALUOP,
  input  logic [5:0]         ID_FUNCT,
  input  logic               ID_REGWRITE,
  input  logic               ID_BRANCH,
  input  logic               WB_REGWRITE,
  input  logic [REGBITS-1:0] WB_RD,
  input  logic [WIDTH-1:0]   WB_DATA,
  output logic [WIDTH-1:0]   ALU_IN1,
  output logic [WIDTH-1:0]   ALU_IN2,
  output logic [3:0]         ALU_CONTROL,
  input  logic [WIDTH-1:0]   ALU_OUT,
  input  logic               ALU_ZERO,
  output logic               MEM_VALID,
  output logic               MEM_REGWRITE,
  output logic [WIDTH-1:0]   MEM_RESULT,
  output logic [WIDTH-1:0]   MEM_STORE_DATA,
  output logic [REGBITS-1:0] MEM_RD,
  output logic               BR_TAKEN,
  output logic [WIDTH-1:0]   BR_TARGET
);
  localparam int NUM_OPS = 2;  // operand A (rs), operand B (rt)

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_OR  = 4'b0011;
  localparam logic [3:0] CTL_SLT = 4'b0100;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_NOP = 4'b1111;

  typedef struct packed {
    logic               valid;
    logic               regwrite;
    logic               branch;
    logic               alusrc;
    logic [1:0]         aluop;
    logic [5:0]         funct;
    logic [REGBITS-1:0] rs;
    logic [REGBITS-1:0] rt;
    logic [REGBITS-1:0] rd;
    logic [WIDTH-1:0]   rs_data;
    logic [WIDTH-1:0]   rt_data;
    logic [WIDTH-1:0]   imm;
    logic [WIDTH-1:0]   pc4;
  } idex_t;

  typedef struct packed {
    logic               valid;
    logic               regwrite;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   store_data;
    logic [REGBITS-1:0] rd;
    logic               br_taken;
    logic [WIDTH-1:0]   br_target;
  } exmem_t;

  idex_t  idex_in, idex_d, idex_q;
  exmem_t exmem_d, exmem_q;

  logic [NUM_OPS-1:0][REGBITS-1:0] op_reg;
  logic [NUM_OPS-1:0][WIDTH-1:0]   op_data;
  logic [NUM_OPS-1:0][WIDTH-1:0]   op_fwd;
  logic                            mem_fwd_en;

  // Incoming decode slot; an invalid decode is turned into an all-zero bubble.
  always_comb begin
    idex_in = '0;
    if (ID_VALID) begin
      idex_in.valid    = 1'b1;
      idex_in.regwrite = ID_REGWRITE;
      idex_in.branch   = ID_BRANCH;
      idex_in.alusrc   = ID_ALUSRC;
      idex_in.aluop    = ID_ALUOP;
      idex_in.funct    = ID_FUNCT;
      idex_in.rs       = ID_RS;
      idex_in.rt       = ID_RT;
      idex_in.rd       = ID_RD;
      idex_in.rs_data  = ID_RS_DATA;
      idex_in.rt_data  = ID_RT_DATA;
      idex_in.imm      = ID_IMM;
      idex_in.pc4      = ID_PC4;
    end
  end

  // ID/EX next state: stall holds (and masks flush), flush inserts a bubble.
  always_comb begin
    idex_d = idex_in;
    if (STALL)      idex_d = idex_q;
    else if (FLUSH) idex_d = '0;
  end

  // ALU control decode; anything not recognised, or a bubble, drives NOP.
  always_comb begin
    ALU_CONTROL = CTL_NOP;
    if (idex_q.valid) begin
      unique case (idex_q.aluop)
        2'b00: ALU_CONTROL = CTL_ADD;
        2'b01: ALU_CONTROL = CTL_SUB;
        2'b11: ALU_CONTROL = CTL_OR;
        2'b10: begin
          case (idex_q.funct)
            6'b100000: ALU_CONTROL = CTL_ADD;
            6'b100010: ALU_CONTROL = CTL_SUB;
            6'b100100: ALU_CONTROL = CTL_AND;
            6'b100101: ALU_CONTROL = CTL_OR;
            6'b101010: ALU_CONTROL = CTL_SLT;
            default:   ALU_CONTROL = CTL_NOP;
          endcase
        end
        default: ALU_CONTROL = CTL_NOP;
      endcase
    end
  end

  // Per-operand source registers and register-file data for the forwarding muxes.
  always_comb begin
    op_reg[0]  = idex_q.rs;
    op_reg[1]  = idex_q.rt;
    op_data[0] = idex_q.rs_data;
    op_data[1] = idex_q.rt_data;
    mem_fwd_en = exmem_q.regwrite & exmem_q.valid;
  end

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    ex_fwd_mux #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_fwd (
      .ex_reg    (op_reg[g]),
      .reg_data  (op_data[g]),
      .mem_fwd_en(mem_fwd_en),
      .mem_rd    (exmem_q.rd),
      .mem_data  (exmem_q.result),
      .wb_fwd_en (WB_REGWRITE),
      .wb_rd     (WB_RD),
      .wb_data   (WB_DATA),
      .fwd_data  (op_fwd[g])
    );
  end

  // Operand drive: immediate replaces operand B when ALUSrc is set.
  always_comb begin
    ALU_IN1 = op_fwd[0];
    ALU_IN2 = idex_q.alusrc ? idex_q.imm : op_fwd[1];
  end

  // EX/MEM next state: capture the ALU response unless stalled.
  always_comb begin
    exmem_d = exmem_q;
    if (!STALL) begin
      exmem_d.valid      = idex_q.valid;
      exmem_d.regwrite   = idex_q.regwrite;
      exmem_d.result     = ALU_OUT;
      exmem_d.store_data = op_fwd[1];
      exmem_d.rd         = idex_q.rd;
      exmem_d.br_taken   = idex_q.valid & idex_q.branch & ALU_ZERO;
      exmem_d.br_target  = idex_q.pc4 + (idex_q.imm << 2);
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      idex_q  <= '0;
      exmem_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
    end
  end

  // Registered EX/MEM outputs.
  always_comb begin
    MEM_VALID      = exmem_q.valid;
    MEM_REGWRITE   = exmem_q.regwrite;
    MEM_RESULT     = exmem_q.result;
    MEM_STORE_DATA = exmem_q.store_data;
    MEM_RD         = exmem_q.rd;
    BR_TAKEN       = exmem_q.br_taken;
    BR_TARGET      = exmem_q.br_target;
  end
endmodule

// File: tb/tb_ex_stage_alu_driver.sv
// Directed bench: a table of single-instruction vectors plus hand-built
// sequences for forwarding, stall/flush and reset-during-stall.
module tb_ex_stage_alu_driver;
  logic        CLK = 1'b0;
  logic        RESET, STALL, FLUSH, ID_VALID;
  logic [4:0]  ID_RS, ID_RT, ID_RD;
  logic [31:0] ID_RS_DATA, ID_RT_DATA, ID_IMM, ID_PC4;
  logic        ID_ALUSRC;
  logic [1:0]  ID_ALUOP;
  logic [5:0]  ID_FUNCT;
  logic        ID_REGWRITE, ID_BRANCH;
  logic        WB_REGWRITE;
  logic [4:0]  WB_RD;
  logic [31:0] WB_DATA;
  logic [31:0] ALU_IN1, ALU_IN2, ALU_OUT;
  logic [3:0]  ALU_CONTROL;
  logic        ALU_ZERO;
  logic        MEM_VALID, MEM_REGWRITE, BR_TAKEN;
  logic [31:0] MEM_RESULT, MEM_STORE_DATA, BR_TARGET;
  logic [4:0]  MEM_RD;

  int checks = 0;
  int errors = 0;

  ex_stage_alu_driver #(.WIDTH(32), .REGBITS(5)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH), .ID_VALID(ID_VALID),
    .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_RD(ID_RD),
    .ID_RS_DATA(ID_RS_DATA), .ID_RT_DATA(ID_RT_DATA), .ID_IMM(ID_IMM), .ID_PC4(ID_PC4),
    .ID_ALUSRC(ID_ALUSRC), .ID_ALUOP(ID_ALUOP), .ID_FUNCT(ID_FUNCT),
    .ID_REGWRITE(ID_REGWRITE), .ID_BRANCH(ID_BRANCH),
    .WB_REGWRITE(WB_REGWRITE), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
    .ALU_IN1(ALU_IN1), .ALU_IN2(ALU_IN2), .ALU_CONTROL(ALU_CONTROL),
    .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO),
    .MEM_VALID(MEM_VALID), .MEM_REGWRITE(MEM_REGWRITE), .MEM_RESULT(MEM_RESULT),
    .MEM_STORE_DATA(MEM_STORE_DATA), .MEM_RD(MEM_RD),
    .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET)
  );

  always #5 CLK = ~CLK;

  // Reference ALU: the combinational unit the block drives.
  always_comb begin
    case (ALU_CONTROL)
      4'b0000: ALU_OUT = ALU_IN1 & ALU_IN2;
      4'b0010: ALU_OUT = ALU_IN1 + ALU_IN2;
      4'b0011: ALU_OUT = ALU_IN1 | ALU_IN2;
      4'b0100: ALU_OUT = ($signed(ALU_IN1) < $signed(ALU_IN2)) ? 32'd1 : 32'd0;
      4'b0110: ALU_OUT = ALU_IN1 - ALU_IN2;
      default: ALU_OUT = 32'd0;
    endcase
    ALU_ZERO = (ALU_OUT == 32'd0);
  end

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_d, rt_d, imm, pc4;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic        regw, br;
    logic [3:0]  e_ctl;
    logic [31:0] e_in1, e_in2, e_res;
    logic        e_taken;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0; ID_VALID = 1'b0;
    ID_RS = '0; ID_RT = '0; ID_RD = '0;
    ID_RS_DATA = '0; ID_RT_DATA = '0; ID_IMM = '0; ID_PC4 = '0;
    ID_ALUSRC = 1'b0; ID_ALUOP = 2'b00; ID_FUNCT = '0;
    ID_REGWRITE = 1'b0; ID_BRANCH = 1'b0;
    WB_REGWRITE = 1'b0; WB_RD = '0; WB_DATA = '0;
  endtask

  task automatic drive(input vec_t v);
    ID_VALID = 1'b1;
    ID_RS = v.rs; ID_RT = v.rt; ID_RD = v.rd;
    ID_RS_DATA = v.rs_d; ID_RT_DATA = v.rt_d; ID_IMM = v.imm; ID_PC4 = v.pc4;
    ID_ALUSRC = v.alusrc; ID_ALUOP = v.aluop; ID_FUNCT = v.funct;
    ID_REGWRITE = v.regw; ID_BRANCH = v.br;
  endtask

  task automatic r_type(input logic [4:0] rs, input logic [31:0] rs_d,
                        input logic [4:0] rt, input logic [31:0] rt_d,
                        input logic [4:0] rd, input logic [5:0] funct);
    vec_t v;
    v = '{rs, rt, rd, rs_d, rt_d, 32'h0, 32'h0, 1'b0, 2'b10, funct, 1'b1, 1'b0,
          4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0};
    drive(v);
  endtask

  initial begin
    vt[0]  = '{5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 32'h0, 1'b0, 2'b10, 6'b100000, 1'b1, 1'b0,
               4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 32'h0};
    vt[1]  = '{5'd1, 5'd2, 5'd3, 32'd3, 32'd9, 32'h0, 32'h0, 1'b0, 2'b10, 6'b101010, 1'b1, 1'b0,
               4'b0100, 32'd3, 32'd9, 32'd1, 1'b0, 32'h0};
    vt[2]  = '{5'd1, 5'd2, 5'd3, 32'h0F, 32'hF0, 32'h0, 32'h0, 1'b0, 2'b10, 6'b100101, 1'b1, 1'b0,
               4'b0011, 32'h0F, 32'hF0, 32'hFF, 1'b0, 32'h0};
    vt[3]  = '{5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 32'h0, 1'b0, 2'b10, 6'b000111, 1'b1, 1'b0,
               4'b1111, 32'd5, 32'd7, 32'd0, 1'b0, 32'h0};
    vt[4]  = '{5'd1, 5'd2, 5'd9, 32'h0F, 32'h1234, 32'hF0, 32'h0, 1'b1, 2'b11, 6'b000000, 1'b1, 1'b0,
               4'b0011, 32'h0F, 32'hF0, 32'hFF, 1'b0, 32'h3C0};
    vt[5]  = '{5'd1, 5'd2, 5'd0, 32'd4, 32'd4, 32'd3, 32'h100, 1'b0, 2'b01, 6'b000000, 1'b0, 1'b1,
               4'b0110, 32'd4, 32'd4, 32'd0, 1'b1, 32'h10C};
    vt[6]  = '{5'd1, 5'd2, 5'd0, 32'd4, 32'd5, 32'd3, 32'h100, 1'b0, 2'b01, 6'b000000, 1'b0, 1'b1,
               4'b0110, 32'd4, 32'd5, 32'hFFFFFFFF, 1'b0, 32'h10C};
    vt[7]  = '{5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'h0, 32'h0, 1'b0, 2'b10, 6'b100010, 1'b1, 1'b0,
               4'b0110, 32'd10, 32'd3, 32'd7, 1'b0, 32'h0};
    vt[8]  = '{5'd1, 5'd2, 5'd3, 32'hFF, 32'h0F, 32'h0, 32'h0, 1'b0, 2'b10, 6'b100100, 1'b1, 1'b0,
               4'b0000, 32'hFF, 32'h0F, 32'h0F, 1'b0, 32'h0};
    vt[9]  = '{5'd1, 5'd2, 5'd8, 32'h100, 32'h0, 32'd8, 32'h0, 1'b1, 2'b00, 6'b000000, 1'b1, 1'b0,
               4'b0010, 32'h100, 32'd8, 32'h108, 1'b0, 32'h20};
    vt[10] = '{5'd1, 5'd2, 5'd3, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h0, 1'b0, 2'b10, 6'b100000, 1'b1, 1'b0,
               4'b0010, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, 32'h0};
    vt[11] = '{5'd6, 5'd6, 5'd0, 32'd6, 32'd6, 32'd2, 32'hFFFFFFFC, 1'b0, 2'b01, 6'b000000, 1'b0, 1'b1,
               4'b0110, 32'd6, 32'd6, 32'd0, 1'b1, 32'h4};

    // Reset with garbage on the inputs.
    idle();
    r_type(5'd0, 32'hDEAD, 5'd9, 32'hBEEF, 5'd4, 6'b100000);
    WB_REGWRITE = 1'b1; WB_RD = 5'd0; WB_DATA = 32'h1111;
    RESET = 1'b1;
    tick(); tick();
    chk("rst_mem_valid", {31'b0, MEM_VALID}, 32'd0);
    chk("rst_mem_regwrite", {31'b0, MEM_REGWRITE}, 32'd0);
    chk("rst_mem_result", MEM_RESULT, 32'd0);
    chk("rst_mem_store", MEM_STORE_DATA, 32'd0);
    chk("rst_mem_rd", {27'b0, MEM_RD}, 32'd0);
    chk("rst_br_taken", {31'b0, BR_TAKEN}, 32'd0);
    chk("rst_br_target", BR_TARGET, 32'd0);
    chk("rst_alu_ctl", {28'b0, ALU_CONTROL}, 32'hF);
    chk("rst_alu_in1", ALU_IN1, 32'd0);
    chk("rst_alu_in2", ALU_IN2, 32'd0);
    idle();
    tick();

    // Table: capture, check ALU drive, then a bubble and check the EX/MEM result.
    for (int i = 0; i < 12; i++) begin
      drive(vt[i]);
      tick();
      chk($sformatf("v%0d_ctl", i), {28'b0, ALU_CONTROL}, {28'b0, vt[i].e_ctl});
      chk($sformatf("v%0d_in1", i), ALU_IN1, vt[i].e_in1);
      chk($sformatf("v%0d_in2", i), ALU_IN2, vt[i].e_in2);
      idle();
      tick();
      chk($sformatf("v%0d_result", i), MEM_RESULT, vt[i].e_res);
      chk($sformatf("v%0d_valid", i), {31'b0, MEM_VALID}, 32'd1);
      chk($sformatf("v%0d_regw", i), {31'b0, MEM_REGWRITE}, {31'b0, vt[i].regw});
      chk($sformatf("v%0d_rd", i), {27'b0, MEM_RD}, {27'b0, vt[i].rd});
      chk($sformatf("v%0d_taken", i), {31'b0, BR_TAKEN}, {31'b0, vt[i].e_taken});
      chk($sformatf("v%0d_target", i), BR_TARGET, vt[i].e_tgt);
    end

    // Back-to-back dependency: add $3 then sub $4=$3-$1 with stale rs data.
    idle(); tick();
    r_type(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 6'b100000);
    tick();
    r_type(5'd3, 32'd0, 5'd1, 32'd5, 5'd4, 6'b100010);
    tick();
    chk("fwd_mem_result", MEM_RESULT, 32'd12);
    chk("fwd_mem_rd", {27'b0, MEM_RD}, 32'd3);
    chk("fwd_in1_mem", ALU_IN1, 32'd12);
    chk("fwd_ctl_sub", {28'b0, ALU_CONTROL}, 32'h6);
    chk("fwd_in2_plain", ALU_IN2, 32'd5);
    WB_REGWRITE = 1'b1; WB_RD = 5'd3; WB_DATA = 32'd9;
    #1;
    chk("fwd_mem_beats_wb", ALU_IN1, 32'd12);
    WB_RD = 5'd1; WB_DATA = 32'h55;
    #1;
    chk("fwd_in2_wb", ALU_IN2, 32'h55);
    WB_REGWRITE = 1'b0; WB_RD = '0; WB_DATA = '0;
    ID_VALID = 1'b0;
    tick();
    chk("fwd_sub_result", MEM_RESULT, 32'd7);
    chk("fwd_store_data", MEM_STORE_DATA, 32'd5);

    // Stall for three cycles mid-stream, with a flush overlapping one of them.
    idle(); tick();
    r_type(5'd1, 32'd20, 5'd2, 32'd22, 5'd5, 6'b100000);
    tick();
    r_type(5'd7, 32'd100, 5'd8, 32'd1, 5'd6, 6'b100010);
    tick();
    r_type(5'd9, 32'h77, 5'd10, 32'h88, 5'd11, 6'b100101);
    STALL = 1'b1;
    for (int c = 0; c < 3; c++) begin
      FLUSH = (c == 1);
      tick();
      chk($sformatf("stall%0d_result", c), MEM_RESULT, 32'd42);
      chk($sformatf("stall%0d_rd", c), {27'b0, MEM_RD}, 32'd5);
      chk($sformatf("stall%0d_in1", c), ALU_IN1, 32'd100);
      chk($sformatf("stall%0d_in2", c), ALU_IN2, 32'd1);
      chk($sformatf("stall%0d_ctl", c), {28'b0, ALU_CONTROL}, 32'h6);
    end
    WB_REGWRITE = 1'b1; WB_RD = 5'd7; WB_DATA = 32'd200;
    #1;
    chk("stall_wb_tracks", ALU_IN1, 32'd200);
    WB_REGWRITE = 1'b0; WB_RD = '0; WB_DATA = '0;
    STALL = 1'b0; FLUSH = 1'b1;
    tick();
    chk("flush_mem_result", MEM_RESULT, 32'd99);
    chk("flush_mem_rd", {27'b0, MEM_RD}, 32'd6);
    chk("flush_ctl", {28'b0, ALU_CONTROL}, 32'hF);
    idle();
    tick();
    chk("flush_mem_valid", {31'b0, MEM_VALID}, 32'd0);
    chk("flush_mem_regw", {31'b0, MEM_REGWRITE}, 32'd0);

    // Reset while stalled clears the held state.
    r_type(5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 6'b100000);
    tick();
    idle();
    tick();
    chk("pre_rst_valid", {31'b0, MEM_VALID}, 32'd1);
    STALL = 1'b1; RESET = 1'b1;
    tick();
    chk("stall_rst_valid", {31'b0, MEM_VALID}, 32'd0);
    chk("stall_rst_result", MEM_RESULT, 32'd0);
    chk("stall_rst_ctl", {28'b0, ALU_CONTROL}, 32'hF);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
